// File: rtl/ddr3_ui_arb.sv
// ddr3_ui_arb: round-robin two-port arbiter onto one MIG UI, with read-tag FIFO steering returned data.
module ddr3_ui_arb #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = DATA_WIDTH/8,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  p0_cmd_valid,
  output logic                  p0_cmd_ready,
  input  logic                  p0_cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] p0_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p0_wr_data,
  input  logic [MASK_WIDTH-1:0] p0_wr_mask,
  output logic                  p0_rd_valid,
  output logic [DATA_WIDTH-1:0] p0_rd_data,
  input  logic                  p1_cmd_valid,
  output logic                  p1_cmd_ready,
  input  logic                  p1_cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] p1_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p1_wr_data,
  input  logic [MASK_WIDTH-1:0] p1_wr_mask,
  output logic                  p1_rd_valid,
  output logic [DATA_WIDTH-1:0] p1_rd_data,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  rd_err
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic last_grant, grant, lat_rnw, cmd_done_q, wd_done_q;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [MASK_WIDTH-1:0] lat_mask;
  logic [CW-1:0] tag_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic tag_mem [TAG_DEPTH];
  logic issue, tag_full, elig0, elig1, take, gnt_id, done_now, push, pop, pop_id;
  assign issue    = state == ISSUE;
  assign tag_full = tag_count == CW'(TAG_DEPTH);
  assign elig0    = p0_cmd_valid & init_calib_complete & (!p0_cmd_rnw | !tag_full);
  assign elig1    = p1_cmd_valid & init_calib_complete & (!p1_cmd_rnw | !tag_full);
  assign take     = !issue & (elig0 | elig1);
  assign gnt_id   = (elig0 & elig1) ? !last_grant : elig1;
  assign app_en       = issue & !cmd_done_q;
  assign app_wdf_wren = issue & !lat_rnw & !wd_done_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = {2'b00, lat_rnw};
  assign app_addr     = lat_addr;
  assign app_wdf_data = lat_data;
  assign app_wdf_mask = lat_mask;
  assign done_now     = issue & (cmd_done_q | app_rdy) & (lat_rnw | wd_done_q | app_wdf_rdy);
  assign p0_cmd_ready = done_now & !grant;
  assign p1_cmd_ready = done_now & grant;
  assign push   = app_en & app_rdy & lat_rnw;
  assign pop    = app_rd_data_valid & (tag_count != '0);
  assign pop_id = tag_mem[rd_ptr];
  always_comb begin
    state_n = issue ? (done_now ? IDLE : ISSUE) : (take ? ISSUE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_rnw    <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_mask   <= '0;
      cmd_done_q <= 1'b0;
      wd_done_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        grant      <= gnt_id;
        last_grant <= gnt_id;
        lat_rnw    <= gnt_id ? p1_cmd_rnw  : p0_cmd_rnw;
        lat_addr   <= gnt_id ? p1_cmd_addr : p0_cmd_addr;
        lat_data   <= gnt_id ? p1_wr_data  : p0_wr_data;
        lat_mask   <= gnt_id ? p1_wr_mask  : p0_wr_mask;
        cmd_done_q <= 1'b0;
        wd_done_q  <= 1'b0;
      end else begin
        if (app_en & app_rdy) cmd_done_q <= 1'b1;
        if (app_wdf_wren & app_wdf_rdy) wd_done_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_count   <= '0;
      rd_err      <= 1'b0;
      p0_rd_valid <= 1'b0;
      p1_rd_valid <= 1'b0;
      p0_rd_data  <= '0;
      p1_rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      tag_count   <= tag_count + CW'(push) - CW'(pop);
      rd_err      <= rd_err | (app_rd_data_valid & !pop);
      p0_rd_valid <= pop & !pop_id;
      p1_rd_valid <= pop & pop_id;
      if (pop & !pop_id) p0_rd_data <= app_rd_data;
      if (pop & pop_id) p1_rd_data <= app_rd_data;
    end
  end
endmodule
